ram_program_loader: RTL

- Initiator side of the RAM manual-programming interface; replaces the front-panel switches as the RAM's programming source.
- Accepts a byte stream from an upstream byte source, e.g. UART receiver: valid strobe plus data.
- Writes the bytes sequentially into the 16x8 program RAM: drives manual_mode, manual_read, address and program_switches.
- Holds the CPU off the RAM (manual_mode high) for the whole load, then reports done or error.

---
 rtl/ram_program_loader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ram_program_loader.sv
// rtl/ram_program_loader.sv - byte-stream loader driving the RAM manual-programming port
// Optional trailing checksum byte check is enabled with LOADER_CHECKSUM_EN.

module ram_program_loader #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              manual_mode,
  output logic              manual_read,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] program_switches,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_OVERRUN  = 2'b10;
  localparam logic [1:0] ERR_CHECKSUM = 2'b11;

  // The counter only has to hold 0..TIMEOUT_CYCLES-1; the expiring cycle jumps straight to ERROR.
  localparam int unsigned       CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          err_q, err_d;
  logic                timeout_hit;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
`endif

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          err_d   = ERR_NONE;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_LOAD: begin
        if (byte_valid) begin
          data_d  = byte_data;
          cnt_d   = '0;
          state_d = S_WRITE;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + byte_data;
`endif
        end else if (timeout_hit) begin
          state_d = S_ERROR;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        // The RAM write itself still completes at this edge even on overrun.
        if (byte_valid) begin
          state_d = S_ERROR;
          err_d   = ERR_OVERRUN;
        end else if (addr_q == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (byte_valid) begin
          cnt_d = '0;
          if (byte_data == sum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
            err_d   = ERR_CHECKSUM;
          end
        end else if (timeout_hit) begin
          state_d = S_ERROR;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign busy             = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_CHECK);
  assign manual_mode      = busy;
  assign manual_read      = (state_q == S_WRITE);
  assign byte_ready       = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign done             = (state_q == S_DONE);
  assign error            = err_q;
  assign address          = addr_q;
  assign program_switches = data_q;

endmodule
